serial_pattern_tx: RTL and testbench

- Upstream stage that produces the serial bit stream `D` consumed by the `code` sequence block, both on the same `Clk`.
- Accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Inserts a programmable idle gap after each word, pulses a frame-done strobe, and counts completed frames.

---
 rtl/serial_pattern_tx.sv | 107 ++++++++++
 tb/tb_serial_pattern_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and shifts it out
// MSB-first. After each word it holds a programmable idle gap and strobes frame completion.
module serial_pattern_tx #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Load_Data,
    input  logic             Load_Valid,
    output logic             Load_Ready,
    output logic             D,
    output logic             D_Valid,
    output logic             Busy,
    output logic             Frame_Done,
    output logic [7:0]       Frame_Count
);

    // state | meaning
    // IDLE  | ready for a word, line held at 0
    // SHIFT | driving word bits MSB-first, one per cycle
    // GAP   | post-frame idle cycles, line held at 0
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]     GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;
    logic             accept;

    assign accept = Load_Valid && Load_Ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            Load_Ready  <= 1'b0;
            D           <= 1'b0;
            D_Valid     <= 1'b0;
            Busy        <= 1'b0;
            Frame_Done  <= 1'b0;
            Frame_Count <= 8'd0;
        end else begin
            Frame_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    Load_Ready <= 1'b1;
                    if (accept) begin
                        // MSB goes straight to D; the register holds the remaining bits
                        state      <= ST_SHIFT;
                        shift_reg  <= {Load_Data[WIDTH-2:0], 1'b0};
                        D          <= Load_Data[WIDTH-1];
                        D_Valid    <= 1'b1;
                        Busy       <= 1'b1;
                        Load_Ready <= 1'b0;
                        bit_cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        D           <= 1'b0;
                        D_Valid     <= 1'b0;
                        Frame_Done  <= 1'b1;
                        Frame_Count <= Frame_Count + 8'd1;
                        if (GAP_CYCLES > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state      <= ST_IDLE;
                            Busy       <= 1'b0;
                            Load_Ready <= 1'b1;
                        end
                    end else begin
                        D         <= shift_reg[WIDTH-1];
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state      <= ST_IDLE;
                        Busy       <= 1'b0;
                        Load_Ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    D          <= 1'b0;
                    D_Valid    <= 1'b0;
                    Busy       <= 1'b0;
                    Load_Ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one instance with a 2-cycle gap and one with no gap share
// the stimulus; an offset-in-frame reference model predicts both.
module tb_serial_pattern_tx;

    localparam int W      = 8;
    localparam int G      = 2;
    localparam int IDLE_K = 1000;

    logic         Clk;
    logic         Reset_n;
    logic [W-1:0] Load_Data;
    logic         Load_Valid;

    logic         rdy, d, dv, busy, fd;
    logic [7:0]   cnt;
    logic         rdy0, d0, dv0, busy0, fd0;
    logic [7:0]   cnt0;

    serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Load_Data(Load_Data), .Load_Valid(Load_Valid),
        .Load_Ready(rdy), .D(d), .D_Valid(dv), .Busy(busy), .Frame_Done(fd), .Frame_Count(cnt)
    );

    serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Load_Data(Load_Data), .Load_Valid(Load_Valid),
        .Load_Ready(rdy0), .D(d0), .D_Valid(dv0), .Busy(busy0), .Frame_Done(fd0), .Frame_Count(cnt0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: k = clock edges since the word was accepted (IDLE_K = no frame)
    bit       m_started = 0;
    int       m_k       = IDLE_K;
    int       m_k0      = IDLE_K;
    int       m_count   = 0;
    int       m_count0  = 0;
    logic [W-1:0] m_word0 = '0;
    bit       acc_main  = 0;
    bit       bitq[$];
    int       frameq[$];

    bit       to_flag    = 0;
    bit       final_chk  = 0;
    bit       final_done = 0;
    bit       wrap_seen  = 0;
    int       frames_seen = 0;

    // {ready, busy, valid, frame_done} expected for a given offset into the frame
    function automatic logic [3:0] exp_ctl(int k, bit started, int g);
        exp_ctl = {started && (k >= W + g), k < W + g, k < W, k == W};
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        acc_main = 0;
        if (!Reset_n) begin
            m_started = 0;
            m_k       = IDLE_K;
            m_k0      = IDLE_K;
            m_count   = 0;
            m_count0  = 0;
            bitq.delete();
            frameq.delete();
        end else begin
            if (Load_Valid && m_started && m_k >= W + G) begin
                acc_main = 1;
                m_k      = 0;
                for (int i = 0; i < W; i++) bitq.push_back(Load_Data[W-1-i]);
                frameq.push_back((m_count + 1) % 256);
            end else if (m_k < IDLE_K) begin
                m_k++;
            end
            if (m_k == W) m_count = (m_count + 1) % 256;

            if (Load_Valid && m_started && m_k0 >= W) begin
                m_k0    = 0;
                m_word0 = Load_Data;
            end else if (m_k0 < IDLE_K) begin
                m_k0++;
            end
            if (m_k0 == W) m_count0 = (m_count0 + 1) % 256;
            m_started = 1;
        end
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge Clk);
        if (!Reset_n) begin
            chk("rst_outs", int'({rdy, d, dv, busy, fd, cnt}), 0);
            chk("rst_outs0", int'({rdy0, d0, dv0, busy0, fd0, cnt0}), 0);
        end else begin
            chk("ctl", int'({rdy, busy, dv, fd}), int'(exp_ctl(m_k, m_started, G)));
            if (dv) begin
                chk("bit_avail", int'(bitq.size() > 0), 1);
                if (bitq.size() > 0) chk("bit", int'(d), int'(bitq.pop_front()));
            end else begin
                chk("d_idle", int'(d), 0);
            end
            if (fd) begin
                frames_seen++;
                if (cnt == 8'd0) wrap_seen = 1;
                chk("frame_avail", int'(frameq.size() > 0), 1);
                if (frameq.size() > 0) chk("frame_count_done", int'(cnt), frameq.pop_front());
            end
            chk("frame_count", int'(cnt), m_count);

            chk("ctl0", int'({rdy0, busy0, dv0, fd0}), int'(exp_ctl(m_k0, m_started, 0)));
            if (m_k0 < W) chk("bit0", int'(d0), int'(m_word0[W-1-m_k0]));
            else          chk("d_idle0", int'(d0), 0);
            chk("frame_count0", int'(cnt0), m_count0);
        end
        if (final_chk && !final_done) begin
            final_done = 1;
            chk("bitq_empty", bitq.size(), 0);
            chk("frameq_empty", frameq.size(), 0);
            chk("accept_timeout", int'(to_flag), 0);
            chk("wrap_seen", int'(wrap_seen), 1);
            chk("enough_frames", int'(frames_seen >= 257), 1);
        end
    end

    task automatic wait_acc();
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!acc_main && n < 50);
        if (!acc_main) to_flag = 1;
    endtask

    initial begin
        Reset_n    = 1'b0;
        Load_Valid = 1'b0;
        Load_Data  = '0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (10) @(negedge Clk);

        Load_Valid = 1'b1;
        Load_Data  = 8'hB4;
        @(negedge Clk);
        Load_Valid = 1'b0;
        Load_Data  = 8'h00;
        repeat (15) @(negedge Clk);

        Load_Valid = 1'b1;
        Load_Data  = 8'hFF;
        wait_acc();
        Load_Data  = 8'h01;
        wait_acc();
        Load_Valid = 1'b0;
        repeat (15) @(negedge Clk);

        repeat (400) begin
            Load_Valid = 1'($urandom_range(0, 1));
            Load_Data  = 8'($urandom);
            @(negedge Clk);
        end
        Load_Valid = 1'b0;
        repeat (15) @(negedge Clk);

        // abandon a frame mid-shift
        Load_Valid = 1'b1;
        Load_Data  = 8'hB4;
        wait_acc();
        Load_Valid = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);

        Load_Valid = 1'b1;
        repeat (256 * (W + G + 1) + 30) begin
            Load_Data = 8'($urandom);
            @(negedge Clk);
        end
        Load_Valid = 1'b0;
        repeat (20) @(negedge Clk);

        final_chk = 1;
        repeat (2) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
